// File: rtl/aes_block_loader.sv
// rtl/aes_block_loader.sv - byte-serial AES block assembler routing blocks to the encrypt/decrypt core
// Optional partial-block idle timeout enabled by defining LOADER_TIMEOUT_EN.
module aes_block_loader #(
    parameter int NBYTES  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                  Clk_i,
    input  logic                  Rst_i,
    input  logic                  Sel_i,
    input  logic [7:0]            Din_i,
    input  logic                  Din_Vld_i,
    output logic                  Din_Rdy_o,
    input  logic                  Enc_Busy_i,
    input  logic                  Dec_Busy_i,
    output logic [NBYTES*8-1:0]   PT_o,
    output logic [NBYTES*8-1:0]   CT_o,
    output logic                  Enc_Start_o,
    output logic                  Dec_Start_o,
    output logic [4:0]            Cnt_o,
    output logic                  Err_o
);

    localparam int         W    = NBYTES * 8;
    localparam logic [4:0] LAST = 5'(NBYTES - 1);

    typedef enum logic {LOAD, ISSUE} state_t;

    state_t         state_q;
    logic [W-1:0]   shift_q;
    logic [W-1:0]   shift_d;
    logic [W-1:0]   pt_q;
    logic [W-1:0]   ct_q;
    logic [4:0]     cnt_q;
    logic           sel_q;
    logic           rdy_q;
    logic           enc_start_q;
    logic           dec_start_q;
    logic           xfer;

`ifdef LOADER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0]  idle_q;
    logic           err_q;
    assign Err_o = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign Err_o = 1'b0;
`endif

    // rdy_q is high exactly while in LOAD, so a transfer can only happen there
    assign xfer    = Din_Vld_i && rdy_q;
    assign shift_d = {shift_q[W-9:0], Din_i};

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state_q     <= LOAD;
            shift_q     <= '0;
            pt_q        <= '0;
            ct_q        <= '0;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            rdy_q       <= 1'b1;
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            idle_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            enc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            case (state_q)
                LOAD: begin
                    if (xfer) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + 5'd1;
                        if (cnt_q == 5'd0) sel_q <= Sel_i;
                        if (cnt_q == LAST) begin
                            state_q <= ISSUE;
                            rdy_q   <= 1'b0;
                        end
`ifdef LOADER_TIMEOUT_EN
                        idle_q <= '0;
                    end else if (cnt_q != 5'd0) begin
                        if (idle_q == IW'(TIMEOUT - 1)) begin
                            idle_q  <= '0;
                            cnt_q   <= '0;
                            shift_q <= '0;
                            err_q   <= 1'b1;
                        end else begin
                            idle_q <= idle_q + IW'(1);
                        end
`endif
                    end
                end
                ISSUE: begin
                    // only the latched target's busy matters; the other core is ignored
                    if (!sel_q && !Enc_Busy_i) begin
                        pt_q        <= shift_q;
                        enc_start_q <= 1'b1;
                        state_q     <= LOAD;
                        cnt_q       <= '0;
                        rdy_q       <= 1'b1;
                    end else if (sel_q && !Dec_Busy_i) begin
                        ct_q        <= shift_q;
                        dec_start_q <= 1'b1;
                        state_q     <= LOAD;
                        cnt_q       <= '0;
                        rdy_q       <= 1'b1;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign Din_Rdy_o   = rdy_q;
    assign PT_o        = pt_q;
    assign CT_o        = ct_q;
    assign Enc_Start_o = enc_start_q;
    assign Dec_Start_o = dec_start_q;
    assign Cnt_o       = cnt_q;

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Input-side counterpart of the AES output selector. Accepts a byte-serial stream, assembles one 128-bit block and latches a route bit: Sel=0 routes to the encrypt core (plaintext), Sel=1 to the decrypt core (ciphertext).
- Hands the block to the chosen core with a one-cycle start pulse once that core is not busy.
- Sits between the host byte interface and the AES encrypt/decrypt cores.

Parameters:
- NBYTES, 16, bytes per block; NBYTES*8 must equal 128.
- TIMEOUT, 1024, idle cycles allowed between bytes of a partial block (used only with the optional feature).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  asynchronous active-high reset.
- Sel  in  1  route select, sampled with the first byte of a block (0 = encrypt/PT, 1 = decrypt/CT).
- Din  in  8  input byte.
- Din_Vld  in  1  Din valid.
- Din_Rdy  out  1  loader can accept a byte.
- Enc_Busy  in  1  encrypt core busy.
- Dec_Busy  in  1  decrypt core busy.
- PT  out  128  plaintext block to the encrypt core.
- CT  out  128  ciphertext block to the decrypt core.
- Enc_Start  out  1  one-cycle start pulse to the encrypt core.
- Dec_Start  out  1  one-cycle start pulse to the decrypt core.
- Cnt  out  5  bytes accepted in the current block (0..16).
- Err  out  1  timeout-discard pulse (tied 0 without the optional feature).

Behaviour:
- Reset (async, Rst=1):
  - State=LOAD; Cnt=0; Din_Rdy=1.
  - PT=0, CT=0, Enc_Start=0, Dec_Start=0, Err=0.
  - Shift register and latched Sel cleared.
  - Reset mid-block discards the partial block; no start is issued.
- Byte transfer happens on a Clk edge with Din_Vld=1 and Din_Rdy=1.
- States:
  - LOAD: Din_Rdy=1.
    - Each transfer shifts Din into the shift register, first byte ending in bits [127:120], big-endian: block = {b0,b1,...,b15}.
    - Cnt increments on each transfer.
    - On the transfer with Cnt=0, Sel is latched; Sel changes later in the block are ignored.
    - On the 16th transfer, next state = ISSUE and Cnt=16.
  - ISSUE: Din_Rdy=0; no further bytes accepted.
    - Latched Sel=0 and Enc_Busy=0: PT <= block, Enc_Start=1 for exactly one cycle, next state LOAD, Cnt=0.
    - Latched Sel=1 and Dec_Busy=0: CT <= block, Dec_Start=1 for exactly one cycle, next state LOAD, Cnt=0.
    - Target busy: stay in ISSUE, no pulse. The other core's busy is ignored.
- Output registers:
  - PT/CT are registered and change only on their own start cycle.
  - The non-selected bus holds its previous value.
  - PT/CT are valid on the same edge the start pulse rises.
  - Enc_Start and Dec_Start are never high together.
- Latency: with target idle, the start pulse asserts 1 cycle after the edge that accepted byte 16. Din_Rdy returns to 1 in the cycle after the pulse edge.
- Back-to-back: the first byte of the next block may be accepted in the cycle the start pulse is high.
- Din_Vld=0 in LOAD: hold all state.
- Cnt never exceeds 16 and wraps to 0 only through ISSUE, reset or timeout.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - An idle counter runs in LOAD while 0<Cnt<16 and no transfer occurs; any transfer clears it.
  - On reaching TIMEOUT, the partial block is discarded: Cnt=0, shift register cleared, Err=1 for one cycle, state stays LOAD.
  - With Cnt=0 the counter is held at 0. In ISSUE the counter is held.
- Undefined: no counter logic; Err tied 0; a partial block waits indefinitely.

Test Plan:
- Encrypt path: Sel=0, bytes 0x00..0x0F continuous, Enc_Busy=0 -> Enc_Start pulse 1 cycle after byte 16. PT=128'h000102030405060708090A0B0C0D0E0F. CT stays 0. Dec_Start never 1.
- Decrypt path, busy stall: Sel=1, bytes 0xF0..0xFF, Dec_Busy=1 for 5 cycles after byte 16 -> Din_Rdy=0 and no pulse for 5 cycles. Then Dec_Start=1 once, CT=128'hF0F1...FF. Enc_Busy toggling has no effect.
- Sel change mid-block: Sel=0 at byte 0, Sel=1 from byte 3 -> Enc_Start fires, PT loaded, CT unchanged.
- Gaps and back-to-back: random Din_Vld gaps, two blocks sent consecutively -> Cnt sequence 0..16,0..; the second block's first byte is accepted during the first start cycle; both blocks correct.
- Async reset at Cnt=7 -> all outputs 0 immediately, no pulse. A following full block is loaded correctly from byte 0.
- With LOADER_TIMEOUT_EN and TIMEOUT=8: 5 bytes then idle 8 cycles -> Err=1 one cycle, Cnt=0. A following 16-byte block yields a correct PT.
